multicycle_alu: RTL

// - Registered, parametrised ALU for the execute stage. Adds xor/sltu, an iterative multiplier and,

---
 rtl/multicycle_alu.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
// Registered, parametrised ALU for the execute stage. Single-cycle ops
// (add/sub/and/or/xor/slt/sltu) complete one cycle after start. mul is an
// iterative shift-add multiplier (N iterations). With ALU_DIV_EN defined, an
// iterative restoring unsigned divider (divu/remu) is also built. Without
// ALU_DIV_EN, opcodes 1001/1010 behave as illegal ops.
//
// Optional feature macro: ALU_DIV_EN
//
// Ports
//   clk        in   1  clock, all state on rising edge
//   rst        in   1  synchronous, active-high reset
//   start      in   1  launch op; sampled only when busy==0
//   opCode     in   4  operation select
//   srcA       in   N  operand A (dividend / multiplicand)
//   srcB       in   N  operand B (divisor / multiplier)
//   busy       out  1  multi-cycle op in flight; start ignored while high
//   done       out  1  one-cycle pulse, aluResult/zero/divByZero updated
//   aluResult  out  N  registered result, holds until next completion
//   zero       out  1  ~|aluResult
//   divByZero  out  1  divu/remu completed with srcB==0
// -----------------------------------------------------------------------------
module multicycle_alu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   opCode,
  input  logic [N-1:0] srcA,
  input  logic [N-1:0] srcB,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] aluResult,
  output logic         zero,
  output logic         divByZero
);

  localparam int CNT_W = $clog2(N) + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b1000;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_op;
  // r_a: operand A / shifted multiplicand / dividend shifting into quotient
  // r_b: operand B / shifted multiplier / divisor (unchanged during divide)
  // r_acc: product accumulator / partial remainder
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [N-1:0]     r_acc;
  logic [N-1:0]     r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [N-1:0]     w_result;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_last;

  assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
  assign done      = r_done;
  assign aluResult = r_result;
  assign zero      = ~|r_result;

  assign w_accept = start && !busy;
  assign w_is_mul = (opCode == OP_MUL);
  assign w_last   = (r_cnt == CNT_W'(N - 1));

`ifdef ALU_DIV_EN
  logic         r_dbz;
  logic         w_dbz;
  logic         w_b_zero;
  logic [N:0]   w_rem_shift;
  logic [N:0]   w_rem_diff;
  logic         w_fits;

  assign w_is_div    = (opCode == OP_DIVU) || (opCode == OP_REMU);
  assign w_b_zero    = (r_b == '0);
  // Bring in the next dividend bit (MSB of r_a) and trial-subtract.
  assign w_rem_shift = {r_acc, r_a[N-1]};
  assign w_rem_diff  = w_rem_shift - {1'b0, r_b};
  // A zero divisor always "fits", giving all-ones quotient and remainder==dividend.
  assign w_fits      = ~w_rem_diff[N] || w_b_zero;
  assign w_dbz       = ((r_op == OP_DIVU) || (r_op == OP_REMU)) && w_b_zero;
  assign divByZero   = r_dbz;
`else
  assign w_is_div    = 1'b0;
  assign divByZero   = 1'b0;
`endif

  // Final result selection, evaluated in S_DONE from latched/iterated state.
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_ADD:  w_result = r_a + r_b;
      OP_SUB:  w_result = r_a - r_b;
      OP_AND:  w_result = r_a & r_b;
      OP_OR:   w_result = r_a | r_b;
      OP_XOR:  w_result = r_a ^ r_b;
      OP_SLT:  w_result = {{(N-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      OP_SLTU: w_result = {{(N-1){1'b0}}, (r_a < r_b)};
      OP_MUL:  w_result = r_acc;
`ifdef ALU_DIV_EN
      OP_DIVU: w_result = r_a;
      OP_REMU: w_result = r_acc;
`endif
      default: w_result = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; S_DONE accepts a new start so issue can be one per cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (w_is_mul)      w_state_next = S_MUL;
          else if (w_is_div) w_state_next = S_DIV;
          else               w_state_next = S_DONE;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iterations, result/flag write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
`ifdef ALU_DIV_EN
      r_dbz    <= 1'b0;
`endif
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_result <= w_result;
`ifdef ALU_DIV_EN
        r_dbz    <= w_dbz;
`endif
      end
      if (w_accept) begin
        r_op  <= opCode;
        r_a   <= srcA;
        r_b   <= srcB;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == S_MUL) begin
        if (r_b[0]) r_acc <= r_acc + r_a;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt + CNT_W'(1);
      end
`ifdef ALU_DIV_EN
      else if (r_state == S_DIV) begin
        r_acc <= w_fits ? w_rem_diff[N-1:0] : w_rem_shift[N-1:0];
        r_a   <= {r_a[N-2:0], w_fits};
        r_cnt <= r_cnt + CNT_W'(1);
      end
`endif
    end
  end

endmodule
